// File: rtl/fp_wb_pkg.sv
// rtl/fp_wb_pkg.sv - shared FP write-back types and constants (optional bypass: FP_WB_BYPASS_EN)
package fp_wb_pkg;

  localparam int REG_IDX_W = 5;
  localparam int NUM_FREGS = 32;

  typedef logic [REG_IDX_W-1:0] freg_idx_t;

  // One-hot bit for register idx within the pending bitmap.
  function automatic logic [NUM_FREGS-1:0] freg_onehot(input freg_idx_t idx);
    logic [NUM_FREGS-1:0] m;
    m = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/fp_wb_writer_rr_arbiter.sv
// rtl/fp_wb_writer_rr_arbiter.sv - round-robin arbiter with registered rotating pointer
module rr_arbiter
  import fp_wb_pkg::*;
#(
  parameter int N = 3,
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     valid,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] gnt_idx,
  output logic             any_grant
);

  logic [PTR_W-1:0] ptr;
  logic [2*N-1:0]   dbl_valid;
  int               idx;

  // Doubling the request vector lets the wrap-around search be a straight scan.
  assign dbl_valid = {valid, valid};

  // Pick the first valid requester at or above ptr, wrapping past N-1.
  always_comb begin
    grant     = '0;
    gnt_idx   = '0;
    any_grant = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      if (!any_grant && dbl_valid[int'(ptr) + k]) begin
        any_grant = 1'b1;
        idx       = (int'(ptr) + k >= N) ? int'(ptr) + k - N : int'(ptr) + k;
        gnt_idx   = PTR_W'(idx);
        grant[idx] = 1'b1;
      end
    end
  end

  // Move the pointer just past the winner so it gets lowest priority next time.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (any_grant) begin
      ptr <= (gnt_idx == PTR_W'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/fp_wb_writer.sv
// rtl/fp_wb_writer.sv - FP regfile write-back merger with pending-write bitmap (optional bypass: FP_WB_BYPASS_EN)
module fp_wb_writer
  import fp_wb_pkg::*;
#(
  parameter int NUM_SRC = 3,
  parameter int DATA_W  = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC-1:0]            src_valid,
  input  logic [REG_IDX_W*NUM_SRC-1:0]  src_rd,
  input  logic [DATA_W*NUM_SRC-1:0]     src_data,
  output logic [NUM_SRC-1:0]            src_ready,
  input  logic                          iss_valid,
  input  logic [REG_IDX_W-1:0]          iss_rd,
  output logic [NUM_FREGS-1:0]          pend_mask,
`ifdef FP_WB_BYPASS_EN
  output logic                          byp_valid,
  output logic [REG_IDX_W-1:0]          byp_rd,
  output logic [DATA_W-1:0]             byp_data,
`endif
  output logic                          f_we,
  output logic [REG_IDX_W-1:0]          f_rd,
  output logic [DATA_W-1:0]             f_wd
);

  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0]   arb_valid;
  logic [NUM_SRC-1:0]   grant;
  logic [PTR_W-1:0]     gnt_idx;
  logic                 any_grant;
  logic [REG_IDX_W-1:0] sel_rd;
  logic [DATA_W-1:0]    sel_data;
  logic [NUM_FREGS-1:0] clr_mask;
  logic [NUM_FREGS-1:0] set_mask;

  // No grants while in reset, so a held result is not consumed and lost.
  assign arb_valid = rst ? '0 : src_valid;

  rr_arbiter #(.N(NUM_SRC)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .valid     (arb_valid),
    .grant     (grant),
    .gnt_idx   (gnt_idx),
    .any_grant (any_grant)
  );

  assign src_ready = grant;

  // Route the winning source's destination and data toward the write port.
  always_comb begin
    sel_rd   = src_rd[int'(gnt_idx)*REG_IDX_W +: REG_IDX_W];
    sel_data = src_data[int'(gnt_idx)*DATA_W +: DATA_W];
  end

`ifdef FP_WB_BYPASS_EN
  assign byp_valid = any_grant;
  assign byp_rd    = sel_rd;
  assign byp_data  = sel_data;
`endif

  // Pending bit clears when consumers can first see the value.
  always_comb begin
    clr_mask = '0;
`ifdef FP_WB_BYPASS_EN
    if (any_grant) clr_mask = freg_onehot(sel_rd);
`else
    if (f_we) clr_mask = freg_onehot(f_rd);
`endif
    set_mask = '0;
    if (iss_valid) set_mask = freg_onehot(iss_rd);
  end

  // Register the granted result one cycle later onto the regfile write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      f_we <= 1'b0;
      f_rd <= '0;
      f_wd <= '0;
    end else begin
      f_we <= any_grant;
      if (any_grant) begin
        f_rd <= sel_rd;
        f_wd <= sel_data;
      end
    end
  end

  // Track outstanding writes; a new issue beats a same-cycle completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_mask <= '0;
    end else begin
      pend_mask <= (pend_mask & ~clr_mask) | set_mask;
    end
  end

endmodule

// File: tb/tb_fp_wb_writer.sv
// tb/tb_fp_wb_writer.sv - self-checking bench for fp_wb_writer (bypass checks under FP_WB_BYPASS_EN)
module tb_fp_wb_writer;

  localparam int N = 3;
  localparam int DW = 32;
  localparam logic [31:0] D0 = 32'h40000000;
  localparam logic [31:0] D1 = 32'h3F800000;
  localparam logic [31:0] D2 = 32'hC0490FDB;
`ifdef FP_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   src_valid;
  logic [5*N-1:0] src_rd;
  logic [DW*N-1:0] src_data;
  logic [N-1:0]   src_ready;
  logic           iss_valid;
  logic [4:0]     iss_rd;
  logic [31:0]    pend_mask;
  logic           f_we;
  logic [4:0]     f_rd;
  logic [DW-1:0]  f_wd;
`ifdef FP_WB_BYPASS_EN
  logic           byp_valid;
  logic [4:0]     byp_rd;
  logic [DW-1:0]  byp_data;
`endif

  int vectors = 0;
  int miscompares = 0;

  fp_wb_writer #(.NUM_SRC(N), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .src_valid (src_valid),
    .src_rd    (src_rd),
    .src_data  (src_data),
    .src_ready (src_ready),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .pend_mask (pend_mask),
`ifdef FP_WB_BYPASS_EN
    .byp_valid (byp_valid),
    .byp_rd    (byp_rd),
    .byp_data  (byp_data),
`endif
    .f_we      (f_we),
    .f_rd      (f_rd),
    .f_wd      (f_wd)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        r;
    logic [2:0]  v;
    logic [14:0] rds;
    logic        iv;
    logic [4:0]  ird;
    logic [2:0]  e_rdy;
    logic        e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_wd;
    logic [31:0] e_p;
    logic [31:0] e_pb;
  } vec_t;

  vec_t tbl[21];

  // random-phase reference state
  bit          have[N];
  logic [4:0]  h_rd[N];
  logic [31:0] h_dat[N];
  int          m_ptr;
  logic [31:0] m_pend;
  logic        m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_wd;

  initial begin
    // rds = {rd2, rd1, rd0}; f_* and pend expectations are after the edge
    tbl[0]  = '{1'b1, 3'b111, {5'd3, 5'd7, 5'd4},  1'b0, 5'd0, 3'b000, 1'b0, 5'd0,  32'h0, 32'h0,   32'h0};
    tbl[1]  = '{1'b0, 3'b111, {5'd3, 5'd7, 5'd4},  1'b0, 5'd0, 3'b001, 1'b1, 5'd4,  D0,    32'h0,   32'h0};
    tbl[2]  = '{1'b0, 3'b010, {5'd3, 5'd7, 5'd4},  1'b0, 5'd0, 3'b010, 1'b1, 5'd7,  D1,    32'h0,   32'h0};
    tbl[3]  = '{1'b0, 3'b000, {5'd3, 5'd7, 5'd4},  1'b0, 5'd0, 3'b000, 1'b0, 5'd7,  D1,    32'h0,   32'h0};
    tbl[4]  = '{1'b0, 3'b111, {5'd3, 5'd7, 5'd4},  1'b0, 5'd0, 3'b100, 1'b1, 5'd3,  D2,    32'h0,   32'h0};
    tbl[5]  = '{1'b0, 3'b111, {5'd3, 5'd7, 5'd4},  1'b0, 5'd0, 3'b001, 1'b1, 5'd4,  D0,    32'h0,   32'h0};
    tbl[6]  = '{1'b0, 3'b111, {5'd3, 5'd7, 5'd4},  1'b0, 5'd0, 3'b010, 1'b1, 5'd7,  D1,    32'h0,   32'h0};
    tbl[7]  = '{1'b0, 3'b111, {5'd3, 5'd7, 5'd4},  1'b0, 5'd0, 3'b100, 1'b1, 5'd3,  D2,    32'h0,   32'h0};
    tbl[8]  = '{1'b0, 3'b000, {5'd3, 5'd7, 5'd4},  1'b1, 5'd5, 3'b000, 1'b0, 5'd3,  D2,    32'h20,  32'h20};
    tbl[9]  = '{1'b0, 3'b000, {5'd3, 5'd7, 5'd4},  1'b0, 5'd0, 3'b000, 1'b0, 5'd3,  D2,    32'h20,  32'h20};
    tbl[10] = '{1'b0, 3'b001, {5'd3, 5'd7, 5'd5},  1'b0, 5'd0, 3'b001, 1'b1, 5'd5,  D0,    32'h20,  32'h0};
    tbl[11] = '{1'b0, 3'b000, {5'd3, 5'd7, 5'd5},  1'b1, 5'd9, 3'b000, 1'b0, 5'd5,  D0,    32'h200, 32'h200};
    tbl[12] = '{1'b0, 3'b010, {5'd3, 5'd9, 5'd5},  1'b0, 5'd0, 3'b010, 1'b1, 5'd9,  D1,    32'h200, 32'h0};
    tbl[13] = '{1'b0, 3'b000, {5'd3, 5'd9, 5'd5},  1'b1, 5'd9, 3'b000, 1'b0, 5'd9,  D1,    32'h200, 32'h200};
    tbl[14] = '{1'b0, 3'b000, {5'd3, 5'd9, 5'd5},  1'b0, 5'd0, 3'b000, 1'b0, 5'd9,  D1,    32'h200, 32'h200};
    tbl[15] = '{1'b0, 3'b010, {5'd3, 5'd12, 5'd5}, 1'b0, 5'd0, 3'b010, 1'b1, 5'd12, D1,    32'h200, 32'h200};
    tbl[16] = '{1'b1, 3'b111, {5'd3, 5'd12, 5'd5}, 1'b0, 5'd0, 3'b000, 1'b0, 5'd0,  32'h0, 32'h0,   32'h0};
    tbl[17] = '{1'b0, 3'b110, {5'd3, 5'd7, 5'd5},  1'b0, 5'd0, 3'b010, 1'b1, 5'd7,  D1,    32'h0,   32'h0};
    tbl[18] = '{1'b0, 3'b000, {5'd3, 5'd7, 5'd5},  1'b1, 5'd0, 3'b000, 1'b0, 5'd7,  D1,    32'h1,   32'h1};
    tbl[19] = '{1'b0, 3'b001, {5'd3, 5'd7, 5'd0},  1'b0, 5'd0, 3'b001, 1'b1, 5'd0,  D0,    32'h1,   32'h0};
    tbl[20] = '{1'b0, 3'b000, {5'd3, 5'd7, 5'd0},  1'b0, 5'd0, 3'b000, 1'b0, 5'd0,  D0,    32'h0,   32'h0};

    rst = 1'b1;
    src_valid = '0;
    src_rd = '0;
    src_data = {D2, D1, D0};
    iss_valid = 1'b0;
    iss_rd = '0;
    @(posedge clk); #1;

    // directed table: reset, single source, rotation, pending set/clear, reset mid-stream, f0
    for (int i = 0; i < 21; i++) begin
      rst = tbl[i].r;
      src_valid = tbl[i].v;
      src_rd = tbl[i].rds;
      iss_valid = tbl[i].iv;
      iss_rd = tbl[i].ird;
      #1;
      chk($sformatf("tbl%0d src_ready", i), 64'(src_ready), 64'(tbl[i].e_rdy));
      @(posedge clk); #1;
      chk($sformatf("tbl%0d f_we", i), 64'(f_we), 64'(tbl[i].e_we));
      chk($sformatf("tbl%0d f_rd", i), 64'(f_rd), 64'(tbl[i].e_rd));
      chk($sformatf("tbl%0d f_wd", i), 64'(f_wd), 64'(tbl[i].e_wd));
      chk($sformatf("tbl%0d pend_mask", i), 64'(pend_mask), 64'(BYP ? tbl[i].e_pb : tbl[i].e_p));
    end

    // hand sequence: pointer at 1, only src0 valid rd=9 -> wrap-around grant
    iss_valid = 1'b0;
    src_valid = 3'b001;
    src_rd = {5'd3, 5'd7, 5'd9};
    src_data = {D2, D1, 32'h40490FDB};
    #1;
    chk("seq9 src_ready", 64'(src_ready), 64'(3'b001));
`ifdef FP_WB_BYPASS_EN
    chk("seq9 byp_valid", 64'(byp_valid), 64'(1'b1));
    chk("seq9 byp_rd", 64'(byp_rd), 64'(5'd9));
    chk("seq9 byp_data", 64'(byp_data), 64'(32'h40490FDB));
`endif
    chk("seq9 f_we before write", 64'(f_we), 64'(1'b0));
    @(posedge clk); #1;
    src_valid = 3'b000;
    chk("seq9 f_we", 64'(f_we), 64'(1'b1));
    chk("seq9 f_rd", 64'(f_rd), 64'(5'd9));
    chk("seq9 f_wd", 64'(f_wd), 64'(32'h40490FDB));
    @(posedge clk); #1;
    chk("seq9 f_we drop", 64'(f_we), 64'(1'b0));

    // randomized phase against the reference model, starting from reset
    rst = 1'b1;
    @(posedge clk); #1;
    m_ptr = 0; m_pend = '0; m_we = 1'b0; m_rd = '0; m_wd = '0;
    for (int s = 0; s < N; s++) begin
      have[s] = 1'b0; h_rd[s] = '0; h_dat[s] = '0;
    end
    for (int c = 0; c < 600; c++) begin
      int g;
      logic [31:0] clr;
      rst = ($urandom_range(0, 59) == 0);
      for (int s = 0; s < N; s++) begin
        if (!have[s] && ($urandom_range(0, 2) == 0)) begin
          have[s] = 1'b1;
          h_rd[s] = 5'($urandom_range(0, 31));
          h_dat[s] = $urandom;
        end
        src_valid[s] = have[s];
        src_rd[s*5 +: 5] = h_rd[s];
        src_data[s*DW +: DW] = h_dat[s];
      end
      iss_valid = ($urandom_range(0, 1) == 1);
      iss_rd = 5'($urandom_range(0, 31));
      #1;
      g = -1;
      if (!rst) begin
        for (int k = 0; k < N; k++) begin
          if (g < 0 && have[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        end
      end
      chk("rnd src_ready", 64'(src_ready), (g >= 0) ? (64'd1 << g) : 64'd0);
`ifdef FP_WB_BYPASS_EN
      chk("rnd byp_valid", 64'(byp_valid), 64'(g >= 0));
      if (g >= 0) begin
        chk("rnd byp_rd", 64'(byp_rd), 64'(h_rd[g]));
        chk("rnd byp_data", 64'(byp_data), 64'(h_dat[g]));
      end
`endif
      if (rst) begin
        m_we = 1'b0; m_rd = '0; m_wd = '0; m_pend = '0; m_ptr = 0;
      end else begin
        clr = '0;
        if (BYP) begin
          if (g >= 0) clr = 32'd1 << h_rd[g];
        end else if (m_we) begin
          clr = 32'd1 << m_rd;
        end
        m_pend = (m_pend & ~clr) | (iss_valid ? (32'd1 << iss_rd) : 32'd0);
        m_we = (g >= 0);
        if (g >= 0) begin
          m_rd = h_rd[g];
          m_wd = h_dat[g];
          m_ptr = (g + 1) % N;
          have[g] = 1'b0;
        end
      end
      @(posedge clk); #1;
      chk("rnd f_we", 64'(f_we), 64'(m_we));
      chk("rnd f_rd", 64'(f_rd), 64'(m_rd));
      chk("rnd f_wd", 64'(f_wd), 64'(m_wd));
      chk("rnd pend_mask", 64'(pend_mask), 64'(m_pend));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
